fetch_unit: RTL and testbench

Instruction fetch and sequencing unit for the single-cycle teaching core. It generates instruction-memory addresses, presents each fetched machine word to the control decoder, and redirects the PC when the decoder asserts Branch and the ALU condition holds. Branch targets come from an internal, software-loadable target lookup table. The block stops on a halt opcode and reports a retired-instruction count.

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing unit: drives the instruction-memory address, tags each
// returned word with its PC and validity, redirects through a branch-target LUT, and stops on halt.
module fetch_unit #(
    parameter int                   PC_W    = 10,
    parameter int                   INSTR_W = 9,
    parameter int                   LUT_W   = 5,
    parameter logic [INSTR_W-1:0]   HALT_OP = 9'h1FF,
    parameter int                   CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stall,
    input  logic               Branch,
    input  logic               Taken,
    input  logic [LUT_W-1:0]   TargetIdx,
    output logic [PC_W-1:0]    ImemAddr,
    input  logic [INSTR_W-1:0] ImemRdata,
    output logic [INSTR_W-1:0] Instr,
    output logic               InstrValid,
    output logic [PC_W-1:0]    InstrPc,
    input  logic               LutWe,
    input  logic [LUT_W-1:0]   LutWaddr,
    input  logic [PC_W-1:0]    LutWdata,
    output logic               Done,
    output logic [CNT_W-1:0]   InstrCount
);

    localparam int             LUT_DEPTH = 2 ** LUT_W;
    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    instrPc_q, instrPc_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [PC_W-1:0]    lut_q [LUT_DEPTH];
    logic [PC_W-1:0]    lutTarget;

    logic               instrValid;
    logic               isHalt;
    logic               takeBranch;

    // The LUT read is combinational on the stored array, so a same-cycle write still returns the old entry.
    assign lutTarget  = lut_q[TargetIdx];

    assign instrValid = valid_q && (state_q == RUN);
    assign isHalt     = instrValid && (ImemRdata == HALT_OP);
    assign takeBranch = instrValid && Branch && Taken;

    assign ImemAddr   = pc_q;
    assign Instr      = ImemRdata;
    assign InstrValid = instrValid;
    assign InstrPc    = instrPc_q;
    assign Done       = done_q;
    assign InstrCount = count_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instrPc_d = instrPc_q;
        valid_d   = valid_q;
        done_d    = done_q;
        count_d   = count_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                    count_d = '0;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (instrValid && (count_q != CNT_MAX)) begin
                        count_d = count_q + CNT_ONE;
                    end
                    // Halt outranks a branch; a taken branch squashes the fall-through word already in flight.
                    if (isHalt) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end else if (takeBranch) begin
                        pc_d      = lutTarget;
                        instrPc_d = pc_q;
                        valid_d   = 1'b0;
                    end else begin
                        pc_d      = pc_q + PC_ONE;
                        instrPc_d = pc_q;
                        valid_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            instrPc_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instrPc_q <= instrPc_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    // Target table is software state and deliberately survives Reset.
    always_ff @(posedge Clk) begin
        if (LutWe) begin
            lut_q[LutWaddr] <= LutWdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed program scenarios followed by randomized traffic,
// all compared against a cycle-level behavioural model built from plain integers and arrays.
module tb_fetch_unit;

    localparam logic [8:0] HALT = 9'h1FF;
    localparam logic [8:0] BR3  = 9'h143;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        taken = 1'b0;
    logic        lutWe = 1'b0;
    logic [4:0]  lutWaddr = '0;
    logic [9:0]  lutWdata = '0;
    logic [8:0]  imemRdata = '0;
    bit          branchAll = 1'b0;
    logic        branch;
    logic [4:0]  targetIdx;

    logic [9:0]  imemAddr, satAddr;
    logic [8:0]  instr, satInstr;
    logic        instrValid, satValid;
    logic [9:0]  instrPc, satPc;
    logic        done, satDone;
    logic [15:0] instrCount;
    logic [3:0]  satCount;

    logic [8:0]  mem [1024];

    bit          mRun = 1'b0;
    bit          mDone = 1'b0;
    bit          mVal = 1'b0;
    int          mPc = 0;
    int          mIpc = 0;
    int          mCnt = 0;
    logic [8:0]  mInstr = '0;
    int          mLut [32];

    int          tests = 0;
    int          fails = 0;

    fetch_unit dut (
        .Clk(clock), .Reset(reset), .Start(start), .Stall(stall),
        .Branch(branch), .Taken(taken), .TargetIdx(targetIdx),
        .ImemAddr(imemAddr), .ImemRdata(imemRdata), .Instr(instr),
        .InstrValid(instrValid), .InstrPc(instrPc),
        .LutWe(lutWe), .LutWaddr(lutWaddr), .LutWdata(lutWdata),
        .Done(done), .InstrCount(instrCount)
    );

    fetch_unit #(.CNT_W(4)) dutSat (
        .Clk(clock), .Reset(reset), .Start(start), .Stall(stall),
        .Branch(branch), .Taken(taken), .TargetIdx(targetIdx),
        .ImemAddr(satAddr), .ImemRdata(imemRdata), .Instr(satInstr),
        .InstrValid(satValid), .InstrPc(satPc),
        .LutWe(lutWe), .LutWaddr(lutWaddr), .LutWdata(lutWdata),
        .Done(satDone), .InstrCount(satCount)
    );

    always #5 clock = ~clock;

    // Synchronous-read instruction memory plus a toy decoder: opcode 101 in the top bits marks a branch.
    always @(posedge clock) imemRdata <= mem[imemAddr];
    assign branch    = branchAll || (imemRdata[8:6] == 3'b101);
    assign targetIdx = imemRdata[4:0];

    function automatic bit isBranchWord(input logic [8:0] w);
        return branchAll || (w[8:6] == 3'b101);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model by the documented rules, then compare on the falling edge.
    task automatic applyStimulus(input bit rst, input bit st, input bit sl, input bit tk,
                                 input bit we, input int wa, input int wd);
        logic [8:0] nextInstr;
        bit         vis;
        int         idx;
        reset = rst; start = st; stall = sl; taken = tk;
        lutWe = we; lutWaddr = wa[4:0]; lutWdata = wd[9:0];

        nextInstr = mem[mPc];
        vis = mRun && mVal;
        idx = int'(mInstr[4:0]);
        if (rst) begin
            mRun = 0; mDone = 0; mVal = 0; mPc = 0; mIpc = 0; mCnt = 0;
        end else if (!mRun) begin
            if (st) begin
                mRun = 1; mDone = 0; mVal = 0; mPc = 0; mCnt = 0;
            end
        end else if (!sl) begin
            if (vis) mCnt++;
            if (vis && mInstr == HALT) begin
                mRun = 0; mDone = 1; mVal = 0;
            end else if (vis && isBranchWord(mInstr) && tk) begin
                mIpc = mPc; mPc = mLut[idx]; mVal = 0;
            end else begin
                mIpc = mPc; mPc = (mPc + 1) % 1024; mVal = 1;
            end
        end
        if (we) mLut[wa % 32] = wd % 1024;
        mInstr = nextInstr;

        @(posedge clock);
        @(negedge clock);

        checkOutput("imemAddr", imemAddr, mPc);
        checkOutput("instrValid", instrValid, mRun && mVal);
        checkOutput("instrPc", instrPc, mIpc);
        checkOutput("done", done, mDone);
        checkOutput("count", instrCount, (mCnt > 65535) ? 65535 : mCnt);
        if (mRun && mVal) checkOutput("instr", instr, mInstr);
        checkOutput("satAddr", satAddr, mPc);
        checkOutput("satValid", satValid, mRun && mVal);
        checkOutput("satCount", satCount, (mCnt > 15) ? 15 : mCnt);
    endtask

    task automatic idle(input int n, input bit tk);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, tk, 0, 0, 0);
    endtask

    task automatic waitForBranch(input bit tk);
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mRun && mVal && isBranchWord(mInstr)) found = 1;
            else applyStimulus(0, 0, 0, tk, 0, 0, 0);
        end
        checkOutput("waitBranch", {31'b0, found}, 1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'h001;
        for (int i = 0; i < 32; i++) mLut[i] = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("resetValid", instrValid, 0);
        checkOutput("resetAddr", imemAddr, 0);

        for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 0, 1, i, (i * 29 + 7) % 1024);
        applyStimulus(0, 0, 0, 0, 1, 3, 40);

        // Straight-line program ending in halt at word 5.
        for (int i = 0; i < 5; i++) mem[i] = 9'(i + 1);
        mem[5] = HALT;
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(9, 0);
        checkOutput("straightDone", done, 1);
        checkOutput("straightCount", instrCount, 6);

        // Taken and not-taken branch at word 2 through LUT[3].
        mem[2] = BR3; mem[40] = 9'h007; mem[41] = HALT; mem[50] = HALT;
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        idle(12, 1);
        checkOutput("takenCount", instrCount, 5);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(12, 0);
        checkOutput("notTakenCount", instrCount, 6);

        // Stall held over a taken branch for three cycles.
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        waitForBranch(1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("stallPc", instrPc, 2);
        checkOutput("stallCount", instrCount, 2);
        idle(10, 1);

        // LUT write racing a taken branch on the same index: the old target is used.
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        waitForBranch(1);
        applyStimulus(0, 0, 0, 1, 1, 3, 50);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("raceTarget", instrPc, 40);
        idle(8, 1);

        // A word that is both a branch and HALT must halt.
        branchAll = 1; mem[0] = HALT;
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        idle(4, 1);
        checkOutput("haltWinsDone", done, 1);
        checkOutput("haltWinsCount", instrCount, 1);
        branchAll = 0;

        // PC wrap with no halt, then a mid-run reset that must keep the LUT.
        for (int i = 0; i < 1024; i++) mem[i] = 9'h00A;
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(1030, 0);
        checkOutput("satHold", satCount, 15);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("midResetCount", instrCount, 0);
        mem[2] = BR3; mem[50] = HALT;
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        idle(10, 1);
        checkOutput("lutKeptCount", instrCount, 4);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("restartClears", satCount, 0);

        // Randomized traffic.
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 39) == 0) ? HALT : 9'($urandom_range(0, 511));
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 7) == 0, int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 1023)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
